linear_layer_seq: RTL and testbench
===================================

// Module: linear_layer_seq
// PURPOSE
// - Parametrised, sequential fixed-point fully-connected layer: out = sat(W*in + b), optional ReLU.
// - Successor to the fixed-size combinational linear layers. Adds signed Qm.n arithmetic, loadable weights/bias,
//   a single time-shared MAC and valid/ready handshakes on both sides.
// - Sits between feature producers and the next layer. Layers chain directly: out_* connects to the next in_*.
// PARAMETERS
// - IN_DIM   3   input vector length (>=1)
// - OUT_DIM  2   output vector length (>=1)
// - DATA_W   8   signed data/weight/bias width
// - FRAC_W   4   fractional bits of the Q format (0 <= FRAC_W < DATA_W)
// - RELU_EN  0   1: clamp negative outputs to 0 after saturation
// PORTS
// - clk      in   1                 clock, all state on rising edge
// - rst      in   1                 asynchronous, active-high reset
// - in_valid in   1                 input vector valid
// - in_ready out  1                 block can accept a vector
// - in_data  in   IN_DIM*DATA_W     element i at [i*DATA_W +: DATA_W], signed
// - out_valid out 1                 output vector valid
// - out_ready in  1                 consumer accepts the vector
// - out_data out  OUT_DIM*DATA_W    element o at [o*DATA_W +: DATA_W], signed
// - out_sat  out  1                 >=1 element of the current out_data saturated
// - cfg_we   in   1                 write strobe, weight or bias
// - cfg_bias in   1                 1: write bias[cfg_addr]; 0: write W[cfg_addr] (row-major, o*IN_DIM+i)
// - cfg_addr in   $clog2(IN_DIM*OUT_DIM+1)  write index
// - cfg_data in   DATA_W            signed value to write
// - busy     out  1                 vector in flight (states MAC or OUT)
// BEHAVIOUR
// - Reset values
//   - in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0, FSM=IDLE.
//   - W and bias RAM reset to 0.
// - FSM states and transitions
//   - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, set o=0, i=0, acc=bias[0]<<<FRAC_W, go to MAC.
//   - MAC: one cycle per product, acc += in[i]*W[o][i].
//   - MAC, i==IN_DIM-1: write the result for row o, then
//     - if o<OUT_DIM-1: o++, i=0, acc reloads from bias[o+1];
//     - else go to OUT.
//   - OUT: out_valid=1, out_data and out_sat stable. On out_ready go to IDLE with in_ready=1 in the next cycle.
//   - No accept is possible in OUT; there is no overlap.
// - Latency: accept edge to out_valid = IN_DIM*OUT_DIM+1 cycles.
// - Throughput: one vector per IN_DIM*OUT_DIM+2 cycles when out_ready is held 1.
// - Arithmetic
//   - Products are 2*DATA_W bits signed.
//   - ACC_W = 2*DATA_W+$clog2(IN_DIM)+1, so the accumulator never wraps.
//   - Result r = (acc + (FRAC_W>0 ? 1<<(FRAC_W-1) : 0)) >>> FRAC_W, i.e. round half up.
//   - r is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and out_sat is set if clamping occurred.
//   - ReLU (RELU_EN=1) is applied after saturation and does not set out_sat.
// - Configuration writes
//   - Accepted only when busy==0. Otherwise ignored, no error.
//   - An out-of-range cfg_addr is ignored.
//   - A write in the same cycle as an accept takes effect before the next MAC cycle.
// - out_sat is cleared on each accept and is sticky for the vector.
// - in_valid deasserting while in_ready==1 is legal; nothing is latched.
// - rst asserted mid-MAC or in OUT: the vector is discarded and all outputs return to reset values
//   asynchronously. W and bias are cleared.
// STRUCTURE
// - Package linear_pkg holds:
//   - the state enum typedef (IDLE, MAC, OUT);
//   - localparam function acc_width(data_w, in_dim);
//   - function sat_round(acc, frac_w, data_w), returning {sat_flag, value}.
// - Sub-module mac_unit (DATA_W, ACC_W): clear/load-bias and accumulate enable. Combinational multiply,
//   registered acc. Hosts the single multiplier.
// - The top level holds the FSM, i/o counters, W/bias register arrays, input latch and output buffer.
// TESTING
// Config for all tests: DATA_W=8, FRAC_W=4, IN_DIM=3, OUT_DIM=2, so 1.0 = 16.
// - Basic
//   - W = {{16,0,0},{0,16,16}}, b = {0,16}, in = {16,32,48}.
//   - Expect out = {16,96}, out_sat=0, out_valid exactly 7 cycles after the accept.
// - Saturation
//   - All W=127, b=127, in = {127,127,127} -> out = {127,127}, out_sat=1.
//   - Negate the inputs (in = -128) -> out = {-128,-128}, out_sat=1.
// - ReLU
//   - RELU_EN=1, W row0 = {-16,0,0}, in[0]=32 -> out[0]=0, out_sat=0.
//   - Same with RELU_EN=0 -> out[0]=-32.
// - Rounding
//   - W[0][0]=8 (0.5), in[0]=1, b=0 -> acc=8 rounds half up -> out[0]=1.
//   - W[0][0]=-8 -> acc=-8 -> out[0]=0.
// - Backpressure
//   - Hold out_ready=0 for 10 cycles in OUT: out_data stable, in_ready=0, in_valid ignored.
//   - cfg_we during busy does not change W; verify on the next vector.
// - Reset mid-MAC
//   - Assert rst on cycle 3 of MAC: out_valid=0 immediately, in_ready=1 after release, W reads back 0.

Source files
------------

// File: rtl/linear_layer_seq_pkg.sv
// Shared types and arithmetic helpers for the sequential fixed-point linear layer.
// Holds the FSM state type, the accumulator width rule and the round/saturate step.
package linear_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int SR_W = 64;

   function automatic int acc_width(input int data_w, input int in_dim);
      return 2*data_w + $clog2(in_dim) + 1;
   endfunction

   // Round half up, then clamp to the signed data_w range. Returns {sat_flag, value}.
   function automatic logic [SR_W:0] sat_round(input logic signed [SR_W-1:0] acc,
                                                input int frac_w, input int data_w);
      logic signed [SR_W-1:0] half, r, hi, lo;
      logic sat;
      half = '0;
      if (frac_w > 0) half = 64'sd1 <<< (frac_w - 1);
      r   = (acc + half) >>> frac_w;
      hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (data_w - 1));
      sat = (r > hi) || (r < lo);
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return {sat, r};
   endfunction

endpackage

// File: rtl/linear_layer_seq_mac.sv
// Single time-shared multiply-accumulate unit for the linear layer.
// On the first product of a row the accumulator restarts from the pre-shifted bias.
module mac_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 19
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     first,
   input  logic                     en,
   input  logic signed [ACC_W-1:0]  load_val,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc_sum
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc;

   assign prod    = a * b;
   assign acc_sum = (first ? load_val : acc) + ACC_W'(prod);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     acc <= '0;
      else if (en) acc <= acc_sum;
   end

endmodule

// File: rtl/linear_layer_seq.sv
// Sequential fixed-point fully-connected layer: out = sat(W*in + b), optional ReLU.
// One MAC cycle per weight; results land in the output buffer as each row finishes.
//
// state | meaning
// IDLE  | ready for a vector, configuration writes accepted
// MAC   | one product per cycle, row result written on the last column
// OUT   | out_valid held with stable data until out_ready
module linear_layer_seq
   import linear_pkg::*;
#(
   parameter int IN_DIM  = 3,
   parameter int OUT_DIM = 2,
   parameter int DATA_W  = 8,
   parameter int FRAC_W  = 4,
   parameter int RELU_EN = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [IN_DIM*DATA_W-1:0]          in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUT_DIM*DATA_W-1:0]         out_data,
   output logic                              out_sat,
   input  logic                              cfg_we,
   input  logic                              cfg_bias,
   input  logic [$clog2(IN_DIM*OUT_DIM+1)-1:0] cfg_addr,
   input  logic [DATA_W-1:0]                 cfg_data,
   output logic                              busy
);

   localparam int ACC_W = acc_width(DATA_W, IN_DIM);
   localparam int N_W   = IN_DIM * OUT_DIM;
   localparam int AW    = $clog2(N_W + 1);
   localparam int IW    = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
   localparam int OW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

   state_t state, state_nxt;
   logic [IW-1:0] i_cnt;
   logic [OW-1:0] o_cnt;
   logic signed [DATA_W-1:0] w_mem    [N_W];
   logic signed [DATA_W-1:0] bias_mem [OUT_DIM];
   logic [IN_DIM*DATA_W-1:0] in_lat;
   logic accept, last_i, last_o, row_done;
   logic [AW-1:0] w_idx;
   logic signed [DATA_W-1:0] x_sel;
   logic signed [ACC_W-1:0]  load_val, acc_sum;
   logic signed [DATA_W-1:0] r_val, r_out;
   logic r_sat;
   logic [SR_W-1-DATA_W:0] sr_hi_unused;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign last_i    = (i_cnt == IW'(IN_DIM - 1));
   assign last_o    = (o_cnt == OW'(OUT_DIM - 1));
   assign row_done  = (state == MAC) && last_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MAC;
         MAC:     if (last_i && last_o) state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_cnt  <= '0;
         o_cnt  <= '0;
         in_lat <= '0;
      end else if (accept) begin
         i_cnt  <= '0;
         o_cnt  <= '0;
         in_lat <= in_data;
      end else if (state == MAC) begin
         if (last_i) begin
            i_cnt <= '0;
            if (!last_o) o_cnt <= o_cnt + 1'b1;
         end else begin
            i_cnt <= i_cnt + 1'b1;
         end
      end
   end

   // Writes only land while idle; the array guard also keeps bias aliasing out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_W; k++)     w_mem[k]    <= '0;
         for (int k = 0; k < OUT_DIM; k++) bias_mem[k] <= '0;
      end else if (cfg_we && state == IDLE) begin
         if (cfg_bias) begin
            if (cfg_addr < AW'(OUT_DIM)) bias_mem[cfg_addr[OW-1:0]] <= cfg_data;
         end else if (cfg_addr < AW'(N_W)) begin
            w_mem[cfg_addr] <= cfg_data;
         end
      end
   end

   assign w_idx    = AW'(o_cnt * IN_DIM + i_cnt);
   assign x_sel    = in_lat[i_cnt*DATA_W +: DATA_W];
   assign load_val = ACC_W'(bias_mem[o_cnt]) <<< FRAC_W;

   mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk      (clk),
      .rst      (rst),
      .first    (i_cnt == '0),
      .en       (state == MAC),
      .load_val (load_val),
      .a        (x_sel),
      .b        (w_mem[w_idx]),
      .acc_sum  (acc_sum)
   );

   assign {r_sat, sr_hi_unused, r_val} = sat_round(SR_W'(acc_sum), FRAC_W, DATA_W);

   always_comb begin
      r_out = r_val;
      if (RELU_EN != 0 && r_val[DATA_W-1]) r_out = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_sat  <= 1'b0;
      end else if (accept) begin
         out_sat  <= 1'b0;
      end else if (row_done) begin
         out_data[o_cnt*DATA_W +: DATA_W] <= r_out;
         out_sat <= out_sat | r_sat;
      end
   end

endmodule

// File: tb/tb_linear_layer_seq.sv
// Directed bench for linear_layer_seq: vector table plus backpressure, config and reset sequences.
// A ReLU-enabled copy runs in lockstep on the same stimulus.
module tb_linear_layer_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic        cfg_we = 1'b0;
   logic        cfg_bias = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [7:0]  cfg_data = '0;

   logic        in_ready, out_valid, out_sat, busy;
   logic [15:0] out_data;
   logic        r_in_ready, r_out_valid, r_out_sat, r_busy;
   logic [15:0] r_out_data;

   int n_cmp = 0;
   int n_err = 0;
   int g0, g1, gsat, gr0, grsat, lat;

   always #5 clk = ~clk;

   linear_layer_seq #(.IN_DIM(3), .OUT_DIM(2), .DATA_W(8), .FRAC_W(4), .RELU_EN(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .cfg_we(cfg_we), .cfg_bias(cfg_bias), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy));

   linear_layer_seq #(.IN_DIM(3), .OUT_DIM(2), .DATA_W(8), .FRAC_W(4), .RELU_EN(1)) dut_relu (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
      .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data), .out_sat(r_out_sat),
      .cfg_we(cfg_we), .cfg_bias(cfg_bias), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(r_busy));

   typedef struct packed {
      logic [47:0] w;
      logic [15:0] b;
      logic [23:0] x;
      logic [7:0]  e0;
      logic [7:0]  e1;
      logic [7:0]  er0;
      logic        esat;
   } vec_t;

   vec_t vt [7];

   function automatic logic [47:0] p6(input int a0, a1, a2, a3, a4, a5);
      return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   function automatic logic [23:0] p3(input int a0, a1, a2);
      return {8'(a2), 8'(a1), 8'(a0)};
   endfunction

   function automatic int el(input logic [15:0] d, input int k);
      logic signed [7:0] t;
      t = d[k*8 +: 8];
      return int'(t);
   endfunction

   function automatic int s8(input logic [7:0] v);
      logic signed [7:0] t;
      t = v;
      return int'(t);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic wr(input logic b, input int a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_bias = b; cfg_addr = 3'(a); cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic load(input logic [47:0] w, input logic [15:0] b);
      for (int k = 0; k < 6; k++) wr(1'b0, k, w[k*8 +: 8]);
      for (int k = 0; k < 2; k++) wr(1'b1, k, b[k*8 +: 8]);
   endtask

   // Accept one vector (any pending cfg write shares the accept cycle), wait, capture, handshake.
   task automatic run_vec(input logic [23:0] x);
      in_data = x; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; cfg_we = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      g0 = el(out_data, 0); g1 = el(out_data, 1); gsat = int'(out_sat);
      gr0 = el(r_out_data, 0); grsat = int'(r_out_sat);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [15:0] snap;
   int wait_n;

   initial begin
      vt[0] = '{w: p6(16, 0, 0, 0, 16, 16), b: {8'd16, 8'd0}, x: p3(16, 32, 48),
                e0: 8'(16), e1: 8'(96), er0: 8'(16), esat: 1'b0};
      vt[1] = '{w: p6(127, 127, 127, 127, 127, 127), b: {8'd127, 8'd127}, x: p3(127, 127, 127),
                e0: 8'(127), e1: 8'(127), er0: 8'(127), esat: 1'b1};
      vt[2] = '{w: p6(127, 127, 127, 127, 127, 127), b: {8'd127, 8'd127}, x: p3(-128, -128, -128),
                e0: 8'(-128), e1: 8'(-128), er0: 8'(0), esat: 1'b1};
      vt[3] = '{w: p6(-16, 0, 0, 0, 0, 0), b: 16'd0, x: p3(32, 0, 0),
                e0: 8'(-32), e1: 8'(0), er0: 8'(0), esat: 1'b0};
      vt[4] = '{w: p6(8, 0, 0, 0, 0, 0), b: 16'd0, x: p3(1, 0, 0),
                e0: 8'(1), e1: 8'(0), er0: 8'(1), esat: 1'b0};
      vt[5] = '{w: p6(-8, 0, 0, 0, 0, 0), b: 16'd0, x: p3(1, 0, 0),
                e0: 8'(0), e1: 8'(0), er0: 8'(0), esat: 1'b0};
      vt[6] = '{w: p6(-24, 0, 0, 0, 0, 0), b: 16'd0, x: p3(1, 0, 0),
                e0: 8'(-1), e1: 8'(0), er0: 8'(0), esat: 1'b0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset in_ready", int'(in_ready), 1);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_data", int'(out_data), 0);
      chk("reset out_sat", int'(out_sat), 0);
      chk("reset busy", int'(busy), 0);
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++) begin
         load(vt[v].w, vt[v].b);
         run_vec(vt[v].x);
         chk($sformatf("vec%0d latency", v), lat, 7);
         chk($sformatf("vec%0d out0", v), g0, s8(vt[v].e0));
         chk($sformatf("vec%0d out1", v), g1, s8(vt[v].e1));
         chk($sformatf("vec%0d out_sat", v), gsat, int'(vt[v].esat));
         chk($sformatf("vec%0d relu out0", v), gr0, s8(vt[v].er0));
         chk($sformatf("vec%0d relu out_sat", v), grsat, int'(vt[v].esat));
      end

      // Backpressure: cfg writes held through MAC and OUT must be ignored.
      load(vt[0].w, vt[0].b);
      in_data = vt[0].x; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cfg_we = 1'b1; cfg_bias = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd64;
      wait_n = 0;
      while (!out_valid && wait_n < 40) begin
         @(posedge clk); #1;
         wait_n++;
      end
      chk("bp out_valid reached", int'(out_valid), 1);
      snap = out_data;
      chk("bp snapshot out0", el(snap, 0), 16);
      in_valid = 1'b1; in_data = p3(1, 2, 3);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp c%0d out_data", c), int'(out_data), int'(snap));
         chk($sformatf("bp c%0d in_ready", c), int'(in_ready), 0);
         chk($sformatf("bp c%0d out_valid", c), int'(out_valid), 1);
      end
      in_valid = 1'b0; cfg_we = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp in_ready after handshake", int'(in_ready), 1);
      chk("bp busy after handshake", int'(busy), 0);
      run_vec(vt[0].x);
      chk("bp next out0 W unchanged", g0, 16);
      chk("bp next out1", g1, 96);

      // Out-of-range writes ignored; write in the accept cycle takes effect.
      wr(1'b1, 2, 8'd100);
      wr(1'b0, 6, 8'd100);
      wr(1'b0, 7, 8'd100);
      cfg_we = 1'b1; cfg_bias = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd32;
      run_vec(vt[0].x);
      chk("accept-cycle write out0", g0, 32);
      chk("oob write out1", g1, 96);
      chk("accept-cycle write latency", lat, 7);

      // Reset on the third MAC cycle.
      in_data = vt[0].x; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre-reset busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mid-reset out_valid", int'(out_valid), 0);
      chk("mid-reset busy", int'(busy), 0);
      chk("mid-reset in_ready", int'(in_ready), 1);
      chk("mid-reset out_data", int'(out_data), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post-reset in_ready", int'(in_ready), 1);
      run_vec(vt[0].x);
      chk("post-reset out0 W cleared", g0, 0);
      chk("post-reset out1 W cleared", g1, 0);
      chk("post-reset out_sat", gsat, 0);
      chk("post-reset latency", lat, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
